// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower of Hanoi move sequencer.
package hanoi_pkg;

  typedef enum logic [1:0] {
    PEG_A = 2'd0,
    PEG_B = 2'd1,
    PEG_C = 2'd2
  } peg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned NDISCS_DEFAULT = 20;

  // Next peg for disc 0: A->B->C->A for an odd disc count, A->C->B->A for even.
  function automatic peg_t disc0_next(input peg_t p, input logic odd_n);
    peg_t n;
    case (p)
      PEG_A:   n = odd_n ? PEG_B : PEG_C;
      PEG_B:   n = odd_n ? PEG_C : PEG_A;
      default: n = odd_n ? PEG_A : PEG_B;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hanoi_top_finder.sv
// Priority encoder: smallest disc index sitting on the given peg, or NDISCS if the peg is empty.
module hanoi_top_finder
  import hanoi_pkg::*;
#(
  parameter int unsigned NDISCS = NDISCS_DEFAULT
) (
  input  logic [2*NDISCS-1:0]         pos,
  input  peg_t                        peg,
  output logic [$clog2(NDISCS+1)-1:0] top
);

  localparam int unsigned TW = $clog2(NDISCS + 1);

  logic found;

  // Scan upward; the first match is the smallest (topmost) disc.
  always_comb begin
    top   = TW'(NDISCS);
    found = 1'b0;
    for (int unsigned i = 0; i < NDISCS; i++) begin
      if (!found && (pos[2*i +: 2] == peg)) begin
        top   = TW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hanoi_solver.sv
// Tower of Hanoi move sequencer: after start, emits the optimal 2^NDISCS-1 moves
// carrying all discs from peg A to peg B over a valid/ready handshake.
// Optional build macro HANOI_MOVE_COUNT_EN exposes the accepted-move counter as move_count.
module hanoi_solver
  import hanoi_pkg::*;
#(
  parameter int unsigned NDISCS = NDISCS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              ready,
  output logic              valid,
  output logic [1:0]        from,
  output logic [1:0]        to,
  output logic              busy,
  output logic              done
`ifdef HANOI_MOVE_COUNT_EN
  ,
  output logic [NDISCS-1:0] move_count
`endif
);

  localparam int unsigned     TW       = $clog2(NDISCS + 1);
  localparam logic            ODD_N    = 1'(NDISCS % 2);
  localparam logic [NDISCS-1:0] CNT_LAST = {NDISCS{1'b1}} - 1'b1;

  state_t              state;
  logic [2*NDISCS-1:0] pos;
  logic [NDISCS-1:0]   cnt;
  peg_t                hold_from;
  peg_t                hold_to;

  logic [TW-1:0] top_a;
  logic [TW-1:0] top_b;
  logic [TW-1:0] top_c;

  peg_t          p0;
  peg_t          px;
  peg_t          py;
  logic [TW-1:0] tx;
  logic [TW-1:0] ty;
  peg_t          mv_from;
  peg_t          mv_to;
  logic [TW-1:0] mv_disc;

  hanoi_top_finder #(.NDISCS(NDISCS)) u_top_a (.pos(pos), .peg(PEG_A), .top(top_a));
  hanoi_top_finder #(.NDISCS(NDISCS)) u_top_b (.pos(pos), .peg(PEG_B), .top(top_b));
  hanoi_top_finder #(.NDISCS(NDISCS)) u_top_c (.pos(pos), .peg(PEG_C), .top(top_c));

  // Choose the next move from the shadow positions and the move parity.
  always_comb begin
    p0 = peg_t'(pos[1:0]);
    px = PEG_B;
    py = PEG_C;
    tx = top_b;
    ty = top_c;
    case (p0)
      PEG_B: begin
        px = PEG_A;
        py = PEG_C;
        tx = top_a;
        ty = top_c;
      end
      PEG_C: begin
        px = PEG_A;
        py = PEG_B;
        tx = top_a;
        ty = top_b;
      end
      default: ;
    endcase

    if (!cnt[0]) begin
      mv_from = p0;
      mv_to   = disc0_next(p0, ODD_N);
      mv_disc = '0;
    end else if (tx < ty) begin
      mv_from = px;
      mv_to   = py;
      mv_disc = tx;
    end else begin
      mv_from = py;
      mv_to   = px;
      mv_disc = ty;
    end
  end

  // Sequencer state, shadow board, move counter and handshake flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pos       <= '0;
      cnt       <= '0;
      hold_from <= PEG_A;
      hold_to   <= PEG_A;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SOLVE;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_SOLVE: begin
          if (ready) begin
            for (int unsigned i = 0; i < NDISCS; i++) begin
              if (TW'(i) == mv_disc) pos[2*i +: 2] <= mv_to;
            end
            cnt       <= cnt + 1'b1;
            hold_from <= mv_from;
            hold_to   <= mv_to;
            if (cnt == CNT_LAST) begin
              state <= ST_DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Live move while valid; otherwise the last accepted move (A/A after reset).
  assign from = valid ? mv_from : hold_from;
  assign to   = valid ? mv_to   : hold_to;

`ifdef HANOI_MOVE_COUNT_EN
  assign move_count = cnt;
`endif

endmodule

// File: tb/tb_hanoi_solver.sv
// Bench for hanoi_solver: instances with 1,2,3,4 and 10 discs, scoreboard of reference moves.
module tb_hanoi_solver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] start;
  logic [4:0] ready;
  logic [4:0] valid_v;
  logic [4:0] busy_v;
  logic [4:0] done_v;
  logic [1:0] from_v [5];
  logic [1:0] to_v   [5];
`ifdef HANOI_MOVE_COUNT_EN
  logic [19:0] mc_v [5];
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];
  logic [1:0] bpos [10];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned N = (g == 4) ? 10 : g + 1;
    logic [1:0] f;
    logic [1:0] t;
`ifdef HANOI_MOVE_COUNT_EN
    logic [N-1:0] mc;
    assign mc_v[g] = 20'(mc);
`endif
    hanoi_solver #(.NDISCS(N)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start[g]),
      .ready   (ready[g]),
      .valid   (valid_v[g]),
      .from    (f),
      .to      (t),
      .busy    (busy_v[g]),
      .done    (done_v[g])
`ifdef HANOI_MOVE_COUNT_EN
      ,
      .move_count (mc)
`endif
    );
    assign from_v[g] = f;
    assign to_v[g]   = t;
  end

  // Reference move m (1-based) of the optimal solution, target peg B.
  function automatic logic [3:0] ref_move(input int unsigned n, input int unsigned m);
    int unsigned f;
    int unsigned t;
    f = (m & (m - 1)) % 3;
    t = ((m | (m - 1)) + 1) % 3;
    if ((n % 2) == 1) begin
      f = (f == 1) ? 2 : (f == 2) ? 1 : 0;
      t = (t == 1) ? 2 : (t == 2) ? 1 : 0;
    end
    return {2'(f), 2'(t)};
  endfunction

  task automatic push_moves(input int unsigned n);
    exp_q.delete();
    for (int unsigned m = 1; m < (1 << n); m++) exp_q.push_back(ref_move(n, m));
  endtask

  function automatic int unsigned btop(input logic [1:0] p);
    for (int unsigned i = 0; i < 10; i++) if (bpos[i] == p) return i;
    return 10;
  endfunction

  task automatic do_reset();
    start   = '0;
    ready   = '0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_start(input int idx);
    start[idx] = 1'b1;
    @(negedge clock);
    start[idx] = 1'b0;
  endtask

  task automatic test_reset();
    start   = '0;
    ready   = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({valid_v[i], busy_v[i], done_v[i], from_v[i], to_v[i]} !== 7'b0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got v=%b b=%b d=%b from=%0d to=%0d want all 0",
                 i, valid_v[i], busy_v[i], done_v[i], from_v[i], to_v[i]);
      end
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ((valid_v | busy_v | done_v) !== 5'b0) begin
      bad++;
      $display("FAIL idle_no_start got valid=%b busy=%b done=%b want 0", valid_v, busy_v, done_v);
    end
  endtask

  task automatic test_sequence(input int idx, input int unsigned n);
    int unsigned nmoves;
    int          cyc;
    logic [3:0]  e;
    logic [3:0]  last;
    nmoves = (1 << n) - 1;
    last   = '0;
    do_reset();
    push_moves(n);
    ready[idx] = 1'b1;
    pulse_start(idx);
    total++;
    if (valid_v[idx] !== 1'b1 || busy_v[idx] !== 1'b1) begin
      bad++;
      $display("FAIL start_latency n=%0d got valid=%b busy=%b want 1 1", n, valid_v[idx], busy_v[idx]);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      total++;
      if (valid_v[idx] !== 1'b1) begin
        bad++;
        $display("FAIL valid_held n=%0d cyc=%0d got %b want 1", n, cyc, valid_v[idx]);
      end
      e    = exp_q.pop_front();
      last = e;
      total++;
      if ({from_v[idx], to_v[idx]} !== e) begin
        bad++;
        $display("FAIL move n=%0d cyc=%0d got %0d->%0d want %0d->%0d",
                 n, cyc, from_v[idx], to_v[idx], e[3:2], e[1:0]);
      end
      @(negedge clock);
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL seq_timeout n=%0d remaining=%0d want 0", n, exp_q.size());
    end
    total++;
    if (valid_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b1) begin
      bad++;
      $display("FAIL completion n=%0d got v=%b b=%b d=%b want 0 0 1",
               n, valid_v[idx], busy_v[idx], done_v[idx]);
    end
    total++;
    if ({from_v[idx], to_v[idx]} !== last) begin
      bad++;
      $display("FAIL hold_last n=%0d got %0d->%0d want %0d->%0d",
               n, from_v[idx], to_v[idx], last[3:2], last[1:0]);
    end
`ifdef HANOI_MOVE_COUNT_EN
    total++;
    if (mc_v[idx] !== 20'(nmoves)) begin
      bad++;
      $display("FAIL move_count n=%0d got %0d want %0d", n, mc_v[idx], nmoves);
    end
`endif
    pulse_start(idx);
    @(negedge clock);
    total++;
    if (valid_v[idx] !== 1'b0 || done_v[idx] !== 1'b1) begin
      bad++;
      $display("FAIL start_in_done n=%0d got v=%b d=%b want 0 1", n, valid_v[idx], done_v[idx]);
    end
    ready[idx] = 1'b0;
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic r;
    do_reset();
    push_moves(3);
    pulse_start(2);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      r = 1'($urandom_range(0, 1));
      ready[2] = r;
      total++;
      if (valid_v[2] !== 1'b1) begin
        bad++;
        $display("FAIL bp_valid cyc=%0d got %b want 1", cyc, valid_v[2]);
      end
      total++;
      if ({from_v[2], to_v[2]} !== exp_q[0]) begin
        bad++;
        $display("FAIL bp_move cyc=%0d ready=%b got %0d->%0d want %0d->%0d",
                 cyc, r, from_v[2], to_v[2], exp_q[0][3:2], exp_q[0][1:0]);
      end
      if (r) void'(exp_q.pop_front());
      @(negedge clock);
      cyc++;
    end
    ready[2] = 1'b0;
    total++;
    if (exp_q.size() != 0 || done_v[2] !== 1'b1 || valid_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL bp_done remaining=%0d got d=%b v=%b want 0 1 0", exp_q.size(), done_v[2], valid_v[2]);
    end
  endtask

  task automatic test_restart_reset();
    int cyc;
    do_reset();
    push_moves(4);
    ready[3] = 1'b1;
    pulse_start(3);
    for (int k = 0; k < 5; k++) begin
      start[3] = (k == 1);
      total++;
      if ({from_v[3], to_v[3]} !== exp_q[0] || valid_v[3] !== 1'b1) begin
        bad++;
        $display("FAIL restart_move k=%0d got v=%b %0d->%0d want 1 %0d->%0d",
                 k, valid_v[3], from_v[3], to_v[3], exp_q[0][3:2], exp_q[0][1:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clock);
    end
    start[3] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (valid_v[3] !== 1'b0 || busy_v[3] !== 1'b0 || from_v[3] !== 2'd0 || to_v[3] !== 2'd0) begin
      bad++;
      $display("FAIL async_reset got v=%b b=%b %0d->%0d want 0 0 0->0",
               valid_v[3], busy_v[3], from_v[3], to_v[3]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    push_moves(4);
    ready[3] = 1'b1;
    pulse_start(3);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      total++;
      if ({from_v[3], to_v[3]} !== exp_q[0] || valid_v[3] !== 1'b1) begin
        bad++;
        $display("FAIL replay_move cyc=%0d got v=%b %0d->%0d want 1 %0d->%0d",
                 cyc, valid_v[3], from_v[3], to_v[3], exp_q[0][3:2], exp_q[0][1:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clock);
      cyc++;
    end
    ready[3] = 1'b0;
    total++;
    if (exp_q.size() != 0 || done_v[3] !== 1'b1) begin
      bad++;
      $display("FAIL replay_done remaining=%0d got d=%b want 0 1", exp_q.size(), done_v[3]);
    end
  endtask

  task automatic test_board();
    int          cyc;
    int unsigned moves;
    int unsigned board_done_at;
    int unsigned tf;
    int unsigned tt;
    logic        all_b;
    do_reset();
    for (int i = 0; i < 10; i++) bpos[i] = 2'd0;
    moves         = 0;
    board_done_at = 0;
    ready[4]      = 1'b1;
    pulse_start(4);
    cyc = 0;
    while (done_v[4] !== 1'b1 && cyc < 3000) begin
      if (valid_v[4] === 1'b1) begin
        tf = btop(from_v[4]);
        tt = btop(to_v[4]);
        total++;
        if (from_v[4] > 2'd2 || to_v[4] > 2'd2 || from_v[4] == to_v[4] || tf >= 10 || tf >= tt) begin
          bad++;
          $display("FAIL illegal_move idx=%0d got %0d->%0d tops %0d %0d", moves, from_v[4], to_v[4], tf, tt);
        end else begin
          bpos[tf] = to_v[4];
        end
        moves++;
        all_b = 1'b1;
        for (int i = 0; i < 10; i++) if (bpos[i] != 2'd1) all_b = 1'b0;
        if (all_b && board_done_at == 0) board_done_at = moves;
      end
      @(negedge clock);
      cyc++;
    end
    ready[4] = 1'b0;
    total++;
    if (board_done_at != 1023 || moves != 1023 || done_v[4] !== 1'b1) begin
      bad++;
      $display("FAIL board_done got board_at=%0d moves=%0d solver_done=%b want 1023 1023 1",
               board_done_at, moves, done_v[4]);
    end
  endtask

  initial begin
    test_reset();
    test_sequence(2, 3);
    test_sequence(1, 2);
    test_sequence(0, 1);
    test_backpressure();
    test_restart_reset();
    test_board();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
